// File: rtl/fetch_pc_gen_pkg.sv
// Shared constants for the fetch PC generator: RV32 PC width, reset PC and
// the fetch FSM state encoding.
package fetch_pc_gen_pkg;

  localparam int unsigned RV32_PC_WIDTH = 32;
  localparam logic [RV32_PC_WIDTH-1:0] DEFAULT_PC = 32'h0000_0000;

  typedef enum logic [0:0] {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_gen_mask_gen.sv
// Slot-to-mask decode for a fetch group: slot k and every later slot are
// valid, earlier slots belong to bytes before the group's entry point.
module fetch_mask_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned SLOT_W      = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
  input  logic [SLOT_W-1:0]      i_slot,
  output logic [FETCH_WIDTH-1:0] o_mask
);

  always_comb begin
    o_mask = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      o_mask[k] = (k >= int'(i_slot));
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: one boot cycle after reset, then emits aligned fetch
// groups, advancing on fire and jumping on flush/redirect (flush wins).
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = RV32_PC_WIDTH,
  parameter int unsigned FETCH_WIDTH = 2,
  parameter logic [PC_WIDTH-1:0] DEFAULT_PC = PC_WIDTH'(fetch_pc_gen_pkg::DEFAULT_PC)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_ready,
  input  logic                   i_flush,
  input  logic [PC_WIDTH-1:0]    i_flush_pc,
  input  logic                   i_redirect,
  input  logic [PC_WIDTH-1:0]    i_redirect_pc,
  output logic                   o_valid,
  output logic [PC_WIDTH-1:0]    o_pc,
  output logic [FETCH_WIDTH-1:0] o_mask,
  output logic                   o_new_stream,
  output fetch_state_e           o_dbg_state
);

  // Handshake: a group transfers (fire) on a rising edge where o_valid and
  // i_ready are both high; o_pc/o_mask/o_new_stream hold while o_valid & !i_ready.

  localparam int unsigned GROUP_BYTES = 4 * FETCH_WIDTH;
  localparam int unsigned OFF_BITS    = $clog2(GROUP_BYTES);
  localparam int unsigned SLOT_W      = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam logic [PC_WIDTH-1:0] GROUP_INC   = PC_WIDTH'(GROUP_BYTES);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK  = ~PC_WIDTH'(GROUP_BYTES - 1);

  fetch_state_e          r_state;
  fetch_state_e          w_state_next;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [PC_WIDTH-1:0]   w_pc_next;
  logic                  r_new_stream;
  logic                  w_new_stream_next;
  logic                  w_fire;
  logic [SLOT_W-1:0]     w_slot;

  assign o_valid      = (r_state == S_RUN);
  assign o_pc         = r_pc;
  assign o_new_stream = r_new_stream;
  assign o_dbg_state  = r_state;
  assign w_fire       = o_valid & i_ready;

  generate
    if (FETCH_WIDTH > 1) begin : g_slot
      assign w_slot = r_pc[OFF_BITS-1:2];
    end else begin : g_slot_single
      assign w_slot = '0;
    end
  endgenerate

  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_new_stream_next = r_new_stream;
    // Redirect targets are word addresses; the low two bits are dropped.
    if (i_flush) begin
      w_state_next      = S_RUN;
      w_pc_next         = {i_flush_pc[PC_WIDTH-1:2], 2'b00};
      w_new_stream_next = 1'b1;
    end else if (i_redirect) begin
      w_state_next      = S_RUN;
      w_pc_next         = {i_redirect_pc[PC_WIDTH-1:2], 2'b00};
      w_new_stream_next = 1'b1;
    end else begin
      case (r_state)
        S_BOOT: w_state_next = S_RUN;
        S_RUN: begin
          if (w_fire) begin
            w_pc_next         = (r_pc & ALIGN_MASK) + GROUP_INC;
            w_new_stream_next = 1'b0;
          end
        end
        default: w_state_next = S_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_BOOT;
      r_pc         <= DEFAULT_PC;
      r_new_stream <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_new_stream <= w_new_stream_next;
    end
  end

  fetch_mask_gen #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .SLOT_W      (SLOT_W)
  ) u_mask_gen (
    .i_slot (w_slot),
    .o_mask (o_mask)
  );

endmodule
